// File: rtl/board_demux_1to4.sv
// Registers an N x N board of W-bit tiles into one of four output channels, each with a FULL/EMPTY handshake.
// Optional build macro BOARD_DEMUX_CLEAR_ON_ACK_EN: zero a channel's board when it is consumed.
module board_demux_1to4 #(
    parameter int W = 12,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] IM [N-1:0][N-1:0],
    input  logic [1:0]   S,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] M0 [N-1:0][N-1:0],
    output logic [W-1:0] M1 [N-1:0][N-1:0],
    output logic [W-1:0] M2 [N-1:0][N-1:0],
    output logic [W-1:0] M3 [N-1:0][N-1:0],
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ack,
    output logic         collision
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_e;

    chan_state_e  state_p1  [4];
    chan_state_e  state_nxt [4];
    logic         coll_p1;
    logic         accept;
    logic [3:0]   wr_sel;
    logic [3:0]   ack_take;
    logic [W-1:0] board_p1 [4][N-1:0][N-1:0];

    // A same-cycle write wins over the ack, so a busy channel streams one board per cycle.
    always_comb begin
        in_ready  = (state_p1[S] == EMPTY) || out_ack[S];
        accept    = in_valid && in_ready;
        wr_sel    = '0;
        ack_take  = '0;
        out_valid = '0;
        for (int k = 0; k < 4; k++) begin
            state_nxt[k] = state_p1[k];
            wr_sel[k]    = accept && (S == 2'(k));
            ack_take[k]  = out_ack[k] && (state_p1[k] == FULL) && !wr_sel[k];
            out_valid[k] = (state_p1[k] == FULL);
            if (wr_sel[k]) begin
                state_nxt[k] = FULL;
            end else if (ack_take[k]) begin
                state_nxt[k] = EMPTY;
            end
        end
    end

    // ---- stage p1: channel state and collision pulse ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                state_p1[k] <= EMPTY;
            end
            coll_p1 <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                state_p1[k] <= state_nxt[k];
            end
            coll_p1 <= in_valid && !in_ready;
        end
    end

    // ---- stage p1: board storage ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        board_p1[k][i][j] <= '0;
                    end
                end
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        if (wr_sel[k]) begin
                            board_p1[k][i][j] <= IM[i][j];
`ifdef BOARD_DEMUX_CLEAR_ON_ACK_EN
                        end else if (ack_take[k]) begin
                            board_p1[k][i][j] <= '0;
`endif
                        end
                    end
                end
            end
        end
    end

    assign collision = coll_p1;

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            assign M0[gi][gj] = board_p1[0][gi][gj];
            assign M1[gi][gj] = board_p1[1][gi][gj];
            assign M2[gi][gj] = board_p1[2][gi][gj];
            assign M3[gi][gj] = board_p1[3][gi][gj];
        end
    end

endmodule

// File: doc/board_demux_1to4.md
BOARD_DEMUX_1TO4 -- requirements
Module: board_demux_1to4

Interface
REQ-001 SHALL have parameter W, default 12: bit width of one tile value.
REQ-002 SHALL have parameter N, default 4: board dimension, giving an N x N array of W-bit tiles.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port IM, input, W x N x N (unpacked [N-1:0][N-1:0]): board to distribute.
REQ-006 SHALL have port S, input, 2 bits: destination channel select, 0..3.
REQ-007 SHALL have port in_valid, input, 1 bit: IM and S are valid this cycle.
REQ-008 SHALL have port in_ready, output, 1 bit: the selected channel can accept this cycle.
REQ-009 SHALL have ports M0, M1, M2, M3, output, W x N x N each: registered per-channel boards.
REQ-010 SHALL have port out_valid, output, 4 bits: bit k means Mk holds an unconsumed board.
REQ-011 SHALL have port out_ack, input, 4 bits: bit k means the consumer takes Mk this cycle.
REQ-012 SHALL have port collision, output, 1 bit: registered one-cycle pulse for a rejected write.

Function
REQ-013 SHALL keep an independent two-state FSM per channel k: EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
REQ-014 SHALL drive in_ready combinationally as (out_valid[S]==0) OR out_ack[S].
REQ-015 SHALL accept on a cycle with in_valid AND in_ready: capture IM into M[S] at the clock edge and set channel S to FULL; latency is 1 cycle.
REQ-016 SHALL move channel k from FULL to EMPTY on out_ack[k] when k is not written in the same cycle.
REQ-017 SHALL, when ack and accept target the same channel in the same cycle, overwrite Mk with IM and leave the channel FULL, so back-to-back throughput is one board per cycle.
REQ-018 SHALL ignore out_ack[k] while channel k is EMPTY, with no state change.
REQ-019 SHALL leave Mk contents unchanged except on accept into k, or as described under Configuration.
REQ-020 SHALL, when in_valid=1 and in_ready=0, discard IM, leave all channels unchanged, and assert collision on the next cycle for exactly one cycle per such cycle.
REQ-021 SHALL let acks on unselected channels proceed in the same cycle as an accept or a collision.
REQ-022 SHALL copy every tile bit-exactly with no arithmetic, and SHALL never write any channel other than the one selected by S.

Reset
REQ-023 SHALL, while rst=0 and regardless of clk, set out_valid=4'b0000, set collision=0, and set all tiles of M0..M3 to 0.
REQ-024 SHALL, on reset asserted mid-transfer, drop any pending accept; the first accept is possible on the first rising edge after rst returns to 1.
REQ-025 SHALL drive in_ready to 1 during reset, since all channels are EMPTY, but no write SHALL occur while rst=0.

Configuration
REQ-026 SHALL support macro BOARD_DEMUX_CLEAR_ON_ACK_EN.
REQ-027 SHALL, when BOARD_DEMUX_CLEAR_ON_ACK_EN is defined, zero all tiles of Mk on the edge where channel k goes FULL to EMPTY.
REQ-028 SHALL, when BOARD_DEMUX_CLEAR_ON_ACK_EN is undefined, make Mk retain its last board after ack.
REQ-029 SHALL, in both builds, follow REQ-017 for a same-cycle ack and accept, so Mk shows the new IM.

Verification
REQ-030 SHALL cover reset release: release rst; in_valid=1, S=2, IM all tiles 12'h800 -> next cycle M2 tiles = 12'h800, out_valid=4'b0100, all other channels 0.
REQ-031 SHALL cover full rejection: channel 1 FULL; in_valid=1, S=1, no ack -> in_ready=0, M1 unchanged, collision=1 for exactly one cycle.
REQ-032 SHALL cover same-cycle ack and write: channel 3 FULL holding 12'h004; out_ack[3]=1 with accept of IM 12'h008 -> M3=12'h008, out_valid[3] stays 1.
REQ-033 SHALL cover clear-on-ack: channel 0 FULL holding 12'h002; out_ack[0]=1 -> out_valid[0]=0, and M0 = 0 with the macro defined, or 12'h002 without it.
REQ-034 SHALL cover asynchronous reset: assert rst=0 between clock edges while all four channels are FULL -> out_valid=0 and all tiles 0 immediately, without waiting for an edge.
REQ-035 SHALL cover a stream: 8 consecutive accepts with S=0,1,2,3,0,1,2,3 and the consumer acking each channel one cycle after its write -> zero collisions, and every board observed in order.
